// File: rtl/learn_note_feeder_pkg.sv
// Shared definitions for the learn-mode note feeder and the falling-note display.
// Holds the song table entry layout, note code encodings, the end-of-song marker,
// the scroll period shared with the display, and the feeder FSM states.
package learn_note_feeder_pkg;

  // vga_clk cycles per scroll tick; the display stage uses the same value.
  localparam int PERIOD_DEFAULT = 100000;

  // A table entry of all zeros terminates a song.
  localparam logic [15:0] END_ENTRY = 16'h0000;

  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_C    = 3'd1,
    NOTE_D    = 3'd2,
    NOTE_E    = 3'd3,
    NOTE_F    = 3'd4,
    NOTE_G    = 3'd5,
    NOTE_A    = 3'd6,
    NOTE_B    = 3'd7
  } note_code_e;

  // Song table entry: [15:13] note code, [12:11] octave shift, [10:8] reserved, [7:0] rows.
  typedef struct packed {
    logic [2:0] code;
    logic [1:0] shift;
    logic [2:0] rsvd;
    logic [7:0] rows;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Note code to one-hot display row: C -> bit 0 .. B -> bit 6; rest -> no bits.
  function automatic logic [7:0] code_to_onehot(input logic [2:0] code);
    if (code == NOTE_REST) return 8'd0;
    return 8'd1 << (code - 3'd1);
  endfunction

endpackage

// File: rtl/learn_scroll_tick.sv
// Scroll tick generator shared by the feeder and the display.
// Ports:
//   vga_clk  in   pixel clock
//   rst_n    in   asynchronous, active-low reset
//   rd_flag  out  high for the one cycle following the last count of each period
module learn_scroll_tick
  import learn_note_feeder_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEFAULT
) (
  input  logic vga_clk,
  input  logic rst_n,
  output logic rd_flag
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == CNT_W'(PERIOD - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rd_flag <= 1'b0;
    end else begin
      cnt     <= at_end ? '0 : cnt + 1'b1;
      rd_flag <= at_end;
    end
  end

endmodule

// File: rtl/learn_note_feeder.sv
// Learn-mode note feeder: walks a song table and expands each entry into a
// row-by-row one-hot note stream for the falling-note display. The stream only
// advances on scroll ticks where the player's keys match the display bottom row.
// Ports:
//   vga_clk       in   pixel clock
//   rst_n         in   asynchronous, active-low reset
//   start         in   pulse: begin song at song_base (accepted in IDLE/DONE only)
//   song_base     in   first table address of the song
//   key           in   player keys, key[7]=C .. key[1]=B
//   vga_bottom    in   display bottom row {note7..note0, shift}
//   rom_addr      out  song table address (synchronous ROM, 1-cycle read)
//   rom_data      in   song table entry
//   note          out  one-hot row, note[0]=C .. note[6]=B
//   shift         out  octave shift of the current entry
//   output_ready  out  song active
//   busy          out  high from start until DONE
//   done          out  high in DONE until the next start
//   note_idx      out  entries completed, saturating
module learn_note_feeder
  import learn_note_feeder_pkg::*;
#(
  parameter int PERIOD     = PERIOD_DEFAULT,
  parameter int GAP_ROWS   = 1,
  parameter int DRAIN_ROWS = 26,
  parameter int ADDR_W     = 8
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] song_base,
  input  logic [7:0]        key,
  input  logic [9:0]        vga_bottom,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        note,
  output logic [1:0]        shift,
  output logic              output_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        note_idx
);

  state_e            state, state_d;
  logic [7:0]        rows_left, rows_left_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        note_d, note_idx_d;
  logic [1:0]        shift_d;
  logic              ready_d, busy_d, done_d;
  logic              rd_flag, adv;
  entry_t            entry;
  logic              unused_bits;

  learn_scroll_tick #(.PERIOD(PERIOD)) u_tick (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .rd_flag (rd_flag)
  );

  assign entry = entry_t'(rom_data);

  // Key order is reversed relative to the display row: key[7]=C sits opposite note0.
  assign adv = rd_flag &&
               (vga_bottom[8:2] == {key[1], key[2], key[3], key[4], key[5], key[6], key[7]});

  assign unused_bits = ^{vga_bottom[9], vga_bottom[1:0], key[0], entry.rsvd};

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    rows_left_d = rows_left;
    rom_addr_d  = rom_addr;
    note_d      = note;
    shift_d     = shift;
    ready_d     = output_ready;
    busy_d      = busy;
    done_d      = done;
    note_idx_d  = note_idx;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rom_addr_d = song_base;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          note_idx_d = 8'd0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        ready_d = 1'b1;
        if (rom_data == END_ENTRY) begin
          note_d      = 8'd0;
          shift_d     = 2'd0;
          rows_left_d = 8'(DRAIN_ROWS);
          state_d     = ST_DRAIN;
        end else begin
          note_d      = code_to_onehot(entry.code);
          shift_d     = entry.shift;
          rows_left_d = (entry.rows == 8'd0) ? 8'd1 : entry.rows;
          state_d     = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (adv) begin
          if (rows_left <= 8'd1) begin
            // Last row consumed: the address bump here doubles as the prefetch,
            // so the next entry sits on rom_data long before the gap ends.
            note_d     = 8'd0;
            rom_addr_d = rom_addr + 1'b1;
            if (note_idx != 8'hFF) note_idx_d = note_idx + 8'd1;
            if (GAP_ROWS == 0) begin
              state_d = ST_FETCH;
            end else begin
              rows_left_d = 8'(GAP_ROWS);
              state_d     = ST_GAP;
            end
          end else begin
            rows_left_d = rows_left - 8'd1;
          end
        end
      end

      ST_GAP: begin
        if (adv) begin
          if (rows_left <= 8'd1) state_d = ST_LOAD;
          else                   rows_left_d = rows_left - 8'd1;
        end
      end

      ST_DRAIN: begin
        if (adv) begin
          if (rows_left <= 8'd1) begin
            rows_left_d = 8'd0;
            ready_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            rows_left_d = rows_left - 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rows_left    <= 8'd0;
      rom_addr     <= '0;
      note         <= 8'd0;
      shift        <= 2'd0;
      output_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      note_idx     <= 8'd0;
    end else begin
      state        <= state_d;
      rows_left    <= rows_left_d;
      rom_addr     <= rom_addr_d;
      note         <= note_d;
      shift        <= shift_d;
      output_ready <= ready_d;
      busy         <= busy_d;
      done         <= done_d;
      note_idx     <= note_idx_d;
    end
  end

endmodule

// File: tb/tb_learn_note_feeder.sv
// Directed bench for learn_note_feeder with a behavioural song ROM and an
// independent scroll tick model; rows are sampled just before each tick edge,
// i.e. the values the display captures.
module tb_learn_note_feeder;

  localparam int PERIOD     = 10;
  localparam int GAP_ROWS   = 1;
  localparam int DRAIN_ROWS = 4;
  localparam int ADDR_W     = 8;

  logic              vga_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic [ADDR_W-1:0] song_base = '0;
  logic [7:0]        key = 8'd0;
  logic [9:0]        vga_bottom = 10'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data = 16'd0;
  logic [7:0]        note;
  logic [1:0]        shift;
  logic              output_ready, busy, done;
  logic [7:0]        note_idx;

  logic [15:0]       rom_mem [256];
  int                tb_cnt;
  logic              tb_rd;
  int                vectors = 0;
  int                miscompares = 0;

  learn_note_feeder #(
    .PERIOD(PERIOD), .GAP_ROWS(GAP_ROWS), .DRAIN_ROWS(DRAIN_ROWS), .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .start        (start),
    .song_base    (song_base),
    .key          (key),
    .vga_bottom   (vga_bottom),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .shift        (shift),
    .output_ready (output_ready),
    .busy         (busy),
    .done         (done),
    .note_idx     (note_idx)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_data <= rom_mem[rom_addr];

  // Scroll tick model: tb_rd high for the cycle after the counter's last value.
  always @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_cnt <= 0;
      tb_rd  <= 1'b0;
    end else begin
      tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
      tb_rd  <= (tb_cnt == PERIOD - 1);
    end
  end

  // Leaves the bench at the falling edge just before a tick (advance) edge.
  task automatic wait_tick();
    int guard;
    guard = 0;
    @(negedge vga_clk);
    while (tb_rd !== 1'b1 && guard < 4 * PERIOD) begin
      @(negedge vga_clk);
      guard++;
    end
    if (tb_rd !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: no scroll tick within %0d cycles", 4 * PERIOD);
    end
  endtask

  // Samples the row the display takes at the next tick, then steps past that edge.
  task automatic capture(output logic [7:0] n, output logic [1:0] s, output logic r,
                         output logic [7:0] idx);
    wait_tick();
    n = note; s = shift; r = output_ready; idx = note_idx;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    wait_tick();
    @(posedge vga_clk);
    @(negedge vga_clk);
    start     = 1'b1;
    song_base = base;
    @(posedge vga_clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rom_addr !== base) begin
      miscompares++;
      $display("FAIL start_accept: busy=%b rom_addr=%h, want busy=1 rom_addr=%h", busy, rom_addr, base);
    end
  endtask

  task automatic test_reset_idle();
    logic [7:0] n, idx;
    logic [1:0] s;
    logic       r;
    repeat (3) @(posedge vga_clk);
    #1;
    vectors++;
    if ({note, shift, output_ready, busy, done, note_idx, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: note=%h shift=%h ready=%b busy=%b done=%b idx=%h addr=%h, want all 0",
               note, shift, output_ready, busy, done, note_idx, rom_addr);
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      capture(n, s, r, idx);
      vectors++;
      if ({n, r, busy, done} !== 11'd0) begin
        miscompares++;
        $display("FAIL idle_tick%0d: note=%h ready=%b busy=%b done=%b, want 0/0/0/0", t, n, r, busy, done);
      end
    end
  endtask

  task automatic test_single_note();
    logic [7:0] exp_n [8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] n, idx;
    logic [1:0] s;
    logic       r;
    do_start(8'h10);
    for (int i = 0; i < 8; i++) begin
      capture(n, s, r, idx);
      vectors++;
      if (n !== exp_n[i] || r !== 1'b1) begin
        miscompares++;
        $display("FAIL single_row%0d: note=%h ready=%b, want note=%h ready=1", i, n, r, exp_n[i]);
      end
      if (i < 4) begin
        vectors++;
        if (s !== 2'd1) begin
          miscompares++;
          $display("FAIL single_shift%0d: shift=%0d, want 1", i, s);
        end
      end
      if (i == 0) begin
        // A start while the song is playing must be ignored.
        @(negedge vga_clk);
        start = 1'b1; song_base = 8'h40;
        @(posedge vga_clk);
        #1;
        start = 1'b0;
        vectors++;
        if (rom_addr !== 8'h10 || note !== 8'h01) begin
          miscompares++;
          $display("FAIL start_ignored: rom_addr=%h note=%h, want 10/01", rom_addr, note);
        end
      end
    end
    vectors++;
    if ({done, busy, output_ready, note, note_idx} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h01}) begin
      miscompares++;
      $display("FAIL single_done: done=%b busy=%b ready=%b note=%h idx=%h, want 1/0/0/00/01",
               done, busy, output_ready, note, note_idx);
    end
  endtask

  task automatic test_rest_then_note();
    logic [7:0] exp_n [9] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] n, idx;
    logic [1:0] s;
    logic       r;
    do_start(8'h20);
    for (int i = 0; i < 9; i++) begin
      capture(n, s, r, idx);
      vectors++;
      if (n !== exp_n[i] || r !== 1'b1) begin
        miscompares++;
        $display("FAIL rest_row%0d: note=%h ready=%b, want note=%h ready=1", i, n, r, exp_n[i]);
      end
    end
    vectors++;
    if (done !== 1'b1 || note_idx !== 8'd2) begin
      miscompares++;
      $display("FAIL rest_done: done=%b idx=%0d, want done=1 idx=2", done, note_idx);
    end
  endtask

  task automatic test_stall_and_rows0();
    logic [7:0] exp_n [11] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_i [11] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    logic [7:0] n, idx;
    logic [1:0] s;
    logic       r;
    do_start(8'h30);
    capture(n, s, r, idx);
    vectors++;
    if (n !== 8'h20) begin
      miscompares++;
      $display("FAIL stall_first: note=%h, want 20", n);
    end
    @(negedge vga_clk);
    vga_bottom = 10'h100;
    key        = 8'h00;
    for (int t = 0; t < 50; t++) begin
      capture(n, s, r, idx);
      vectors++;
      if (n !== 8'h20 || r !== 1'b1 || idx !== 8'd0) begin
        miscompares++;
        $display("FAIL stall_tick%0d: note=%h ready=%b idx=%0d, want 20/1/0", t, n, r, idx);
      end
    end
    @(negedge vga_clk);
    key = 8'h02;
    // Four A rows remain after the stall, then gap, one G row (rows=0), gap, drain.
    for (int i = 0; i < 11; i++) begin
      capture(n, s, r, idx);
      vectors++;
      if (n !== exp_n[i] || idx !== exp_i[i]) begin
        miscompares++;
        $display("FAIL resume_row%0d: note=%h idx=%0d, want note=%h idx=%0d", i, n, idx, exp_n[i], exp_i[i]);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_done: done=%b, want 1", done);
    end
    vga_bottom = 10'd0;
    key        = 8'd0;
  endtask

  task automatic test_reset_mid_play();
    logic [7:0] n, idx;
    logic [1:0] s;
    logic       r;
    do_start(8'h10);
    capture(n, s, r, idx);
    vectors++;
    if (n !== 8'h01 || note !== 8'h01) begin
      miscompares++;
      $display("FAIL midplay_row: note=%h, want 01", n);
    end
    @(negedge vga_clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({note, shift, output_ready, busy, done, note_idx, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL midplay_reset: note=%h shift=%h ready=%b busy=%b done=%b idx=%h addr=%h, want all 0",
               note, shift, output_ready, busy, done, note_idx, rom_addr);
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    do_start(8'h10);
    capture(n, s, r, idx);
    vectors++;
    if (n !== 8'h01 || s !== 2'd1 || r !== 1'b1) begin
      miscompares++;
      $display("FAIL replay_row: note=%h shift=%0d ready=%b, want 01/1/1", n, s, r);
    end
  endtask

  initial begin
    foreach (rom_mem[i]) rom_mem[i] = 16'h0000;
    rom_mem[8'h10] = 16'h2803;  // C, shift 1, 3 rows
    rom_mem[8'h11] = 16'h0000;
    rom_mem[8'h20] = 16'h0002;  // rest, 2 rows
    rom_mem[8'h21] = 16'h6001;  // E, 1 row
    rom_mem[8'h22] = 16'h0000;
    rom_mem[8'h30] = 16'hC005;  // A, 5 rows
    rom_mem[8'h31] = 16'hA000;  // G, rows=0 -> 1 row
    rom_mem[8'h32] = 16'h0000;

    test_reset_idle();
    test_single_note();
    test_rest_then_note();
    test_stall_and_rows0();
    test_reset_mid_play();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
